// File: rtl/priority_encoder_queue.sv
// Sticky request capture with a fixed-priority drain onto a single-register valid/ready stage.
// Define PENC_OVERFLOW_EN to add a sticky Overflow_Out flag that reports merged requests.
module priority_encoder_queue #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned IDX_W     = $clog2(WIDTH),
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Encoder_In,
  output logic [IDX_W-1:0] Binary_Out,
  output logic             Valid_Out,
  input  logic             Ready_In,
  output logic [WIDTH-1:0] Pending_Out,
`ifdef PENC_OVERFLOW_EN
  output logic             Overflow_Out,
`endif
  output logic             Empty_Out
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] bin_q, bin_d;
  logic [IDX_W-1:0] sel;
  logic [WIDTH-1:0] sel_oh;
  logic [WIDTH-1:0] clear_mask;
  logic             load;
  logic             has_pend;

  // Walk from the low-priority end so the last hit is the winner.
  always_comb begin
    sel    = '0;
    sel_oh = '0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (pending_q[i]) begin
          sel       = IDX_W'(i);
          sel_oh    = '0;
          sel_oh[i] = 1'b1;
        end
      end
    end else begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (pending_q[i]) begin
          sel       = IDX_W'(i);
          sel_oh    = '0;
          sel_oh[i] = 1'b1;
        end
      end
    end
  end

  assign has_pend = |pending_q;
  assign load     = (state_q == StIdle) || Ready_In;

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    clear_mask = '0;
    if (load) begin
      if (has_pend) begin
        state_d    = StHold;
        bin_d      = sel;
        clear_mask = sel_oh;
      end else begin
        state_d = StIdle;
      end
    end
  end

  // A new request on the bit being cleared re-sets it, so nothing is lost.
  assign pending_d = (pending_q & ~clear_mask) | Encoder_In;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      pending_q <= pending_d;
    end
  end

`ifdef PENC_OVERFLOW_EN
  logic overflow_q, overflow_d;
  logic merge;

  assign merge      = |(Encoder_In & pending_q & ~clear_mask);
  assign overflow_d = overflow_q | merge;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign Overflow_Out = overflow_q;
`endif

  assign Binary_Out  = bin_q;
  assign Valid_Out   = (state_q == StHold);
  assign Pending_Out = pending_q;
  assign Empty_Out   = !has_pend && (state_q == StIdle);

endmodule

// File: tb/tb_priority_encoder_queue.sv
// Scoreboard bench: two instances (16-bit LSB-first, 5-bit MSB-first) against a bit-vector model.
module tb_priority_encoder_queue;

  localparam int unsigned W0 = 16;
  localparam int unsigned W1 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [W0-1:0] enc0;
  logic [W1-1:0] enc1;
  logic          rdy0, rdy1;
  logic [3:0]    bin0;
  logic [2:0]    bin1;
  logic          val0, val1, emp0, emp1;
  logic [W0-1:0] pend0;
  logic [W1-1:0] pend1;
`ifdef PENC_OVERFLOW_EN
  logic          ovf0, ovf1;
`endif

  priority_encoder_queue #(.WIDTH(W0), .MSB_FIRST(0)) u_lsb16 (
    .clk         (clk),
    .rst         (rst),
    .Encoder_In  (enc0),
    .Binary_Out  (bin0),
    .Valid_Out   (val0),
    .Ready_In    (rdy0),
    .Pending_Out (pend0),
`ifdef PENC_OVERFLOW_EN
    .Overflow_Out(ovf0),
`endif
    .Empty_Out   (emp0)
  );

  priority_encoder_queue #(.WIDTH(W1), .MSB_FIRST(1)) u_msb5 (
    .clk         (clk),
    .rst         (rst),
    .Encoder_In  (enc1),
    .Binary_Out  (bin1),
    .Valid_Out   (val1),
    .Ready_In    (rdy1),
    .Pending_Out (pend1),
`ifdef PENC_OVERFLOW_EN
    .Overflow_Out(ovf1),
`endif
    .Empty_Out   (emp1)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          started = 1'b0;

  // Reference state: pending set as a plain bit vector plus the presented index.
  logic [63:0] m_pend[2];
  logic        m_val[2];
  int          m_bin[2];
  logic        m_ovf[2];
  int          exp_q[2][$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lowest set bit = log2 of the isolated LSB; highest set bit = floor(log2(p)).
  function automatic int pick(input logic [63:0] p, input bit msbf);
    if (msbf) return $clog2(p + 64'd1) - 1;
    return $clog2(p & (~p + 64'd1));
  endfunction

  task automatic model_edge(input int k, input logic [63:0] enc, input bit rd, input bit rs,
                            input bit msbf);
    logic [63:0] clr;
    int s;
    clr = '0;
    if (rs) begin
      m_pend[k] = '0;
      m_val[k]  = 1'b0;
      m_bin[k]  = 0;
      m_ovf[k]  = 1'b0;
      return;
    end
    if (!m_val[k] || rd) begin
      if (m_pend[k] != 0) begin
        s        = pick(m_pend[k], msbf);
        m_bin[k] = s;
        m_val[k] = 1'b1;
        clr      = 64'd1 << s;
      end else begin
        m_val[k] = 1'b0;
      end
    end
    if ((enc & m_pend[k] & ~clr) != 0) m_ovf[k] = 1'b1;
    m_pend[k] = (m_pend[k] & ~clr) | enc;
  endtask

  // Apply inputs for one cycle; a handshake in this cycle is queued as an expected transfer.
  task automatic cyc(input logic [W0-1:0] e0, input logic [W1-1:0] e1, input bit r0,
                     input bit r1, input bit rs);
    enc0 = e0;
    enc1 = e1;
    rdy0 = r0;
    rdy1 = r1;
    rst  = rs;
    if (!rs) begin
      if (m_val[0] && r0) exp_q[0].push_back(m_bin[0]);
      if (m_val[1] && r1) exp_q[1].push_back(m_bin[1]);
    end
    @(posedge clk);
    model_edge(0, 64'(e0), r0, rs, 1'b0);
    model_edge(1, 64'(e1), r1, rs, 1'b1);
    #1;
  endtask

  task automatic check_inst(input int k, input logic v, input logic [63:0] b,
                            input logic [63:0] p, input logic e, input logic rd);
    string t;
    int    exp_idx;
    t = (k == 0) ? "w16_lsb" : "w5_msb";
    chk({t, ".valid"}, 64'(v), 64'(m_val[k]));
    chk({t, ".pending"}, p, m_pend[k]);
    chk({t, ".empty"}, 64'(e), 64'((m_pend[k] == 0) && !m_val[k]));
    chk({t, ".binary_out"}, b, 64'(m_bin[k]));
    if (v && rd && !rst) begin
      if (exp_q[k].size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s.xfer: got transfer idx %0d, expected no transfer at %0t", t, b, $time);
      end else begin
        exp_idx = exp_q[k].pop_front();
        chk({t, ".xfer_idx"}, b, 64'(exp_idx));
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check_inst(0, val0, 64'(bin0), 64'(pend0), emp0, rdy0);
      check_inst(1, val1, 64'(bin1), 64'(pend1), emp1, rdy1);
`ifdef PENC_OVERFLOW_EN
      chk("w16_lsb.overflow", 64'(ovf0), 64'(m_ovf[0]));
      chk("w5_msb.overflow", 64'(ovf1), 64'(m_ovf[1]));
`endif
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = '0;
      m_val[k]  = 1'b0;
      m_bin[k]  = 0;
      m_ovf[k]  = 1'b0;
    end
    rst  = 1'b1;
    enc0 = '0;
    enc1 = '0;
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    cyc('0, '0, 1'b0, 1'b0, 1'b1);
    cyc('0, '0, 1'b0, 1'b0, 1'b1);
    started = 1'b1;

    repeat (5) cyc('0, '0, 1'b1, 1'b1, 1'b0);

    // Multi-hot pulses drained in priority order.
    cyc(16'h0124, 5'b10001, 1'b1, 1'b1, 1'b0);
    repeat (6) cyc('0, '0, 1'b1, 1'b1, 1'b0);
    cyc(16'h8421, 5'b10101, 1'b1, 1'b1, 1'b0);
    repeat (6) cyc('0, '0, 1'b1, 1'b1, 1'b0);

    // Backpressure with accumulation during the stall.
    cyc(16'h0003, 5'b00011, 1'b0, 1'b0, 1'b0);
    repeat (10) cyc('0, '0, 1'b0, 1'b0, 1'b0);
    cyc(16'h8000, 5'b10000, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc('0, '0, 1'b0, 1'b0, 1'b0);
    repeat (6) cyc('0, '0, 1'b1, 1'b1, 1'b0);

    // Set-wins: re-pulse bit 0 in the cycle it is being loaded.
    cyc(16'h0001, 5'b00001, 1'b1, 1'b1, 1'b0);
    cyc(16'h0001, 5'b00001, 1'b1, 1'b1, 1'b0);
    repeat (5) cyc('0, '0, 1'b1, 1'b1, 1'b0);

    // Merge on a stalled pending bit.
    cyc(16'h0008, 5'b01000, 1'b0, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0, 1'b0);
    cyc(16'h0008, 5'b01000, 1'b0, 1'b0, 1'b0);
    cyc(16'h0008, 5'b01000, 1'b0, 1'b0, 1'b0);
    repeat (5) cyc('0, '0, 1'b1, 1'b1, 1'b0);

    // Mid-stream reset with a transfer in flight.
    cyc(16'hFFFF, 5'b11111, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc('0, '0, 1'b1, 1'b1, 1'b0);
    cyc('0, '0, 1'b1, 1'b1, 1'b1);
    repeat (3) cyc('0, '0, 1'b1, 1'b1, 1'b0);

    for (int n = 0; n < 400; n++) begin
      cyc(W0'($urandom & $urandom & $urandom), W1'($urandom & $urandom),
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 79) == 0));
    end

    repeat (40) cyc('0, '0, 1'b1, 1'b1, 1'b0);

    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (exp_q[k].size() != 0) begin
        n_bad++;
        $display("FAIL drain%0d: %0d expected transfers never seen, required 0", k,
                 exp_q[k].size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
